ram_rd_port: RTL and testbench

Read-side front end for the team's synchronous single-port RAM. Takes read requests over a valid/ready handshake and drives the RAM read enable and address. Tracks reads in flight through the RAM's fixed read latency, then buffers the returned 9-bit words in a small FIFO. Responses go to the consumer in request order with their own valid/ready handshake. It sits between the RAM array and any client that reads it, the counterpart to the existing write path.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_rd_fifo.sv | 79 +++++++
 rtl/ram_rd_port.sv | 84 ++++++++
 tb/tb_ram_rd_port.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM read path.
//   DEF_DATA_W / DEF_ADDR_W : default word and address widths of the RAM
//   data_t / addr_t         : word and address types at the default widths
//   cnt_w(n)                : bits needed to hold a count of 0..n
package ram_pkg;
  localparam int DEF_DATA_W = 9;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding RAM read data until the consumer takes it.
// Depth need not be a power of two; the pointers wrap explicitly.
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write din at the tail
//   pop, dout   : advance the head; dout is the current head entry
//   full, empty : occupancy flags
//   count       : number of entries held
module ram_rd_fifo
  import ram_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 9,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is only dropped when nothing leaves.
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) rd_d = ptr_inc(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_cnt_bound:   assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_W'(DEPTH));
endmodule

// File: rtl/ram_rd_port.sv
// Read-side front end of the synchronous single-port RAM.
// Requests are accepted on a valid/ready handshake and issued straight to the
// RAM; a 1-bit tag pipe follows each read through the RAM latency and pushes
// the returned word into the response FIFO. Responses leave in request order.
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid, req_ready, req_addr   : read request handshake
//   rsp_valid, rsp_ready, rsp_data   : response handshake, data is FIFO head
//   ram_re, ram_addr, ram_rdata      : RAM read port (data RD_LAT after re)
module ram_rd_port
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata
);
  // Two extra slots beyond the RAM latency let the registered credit check
  // sustain one read per cycle while the consumer keeps up.
  localparam int OUT_DEPTH = RD_LAT + 2;
  localparam int CNT_W     = cnt_w(OUT_DEPTH);

  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    credits_used;
  logic              accept, tap, pop, fifo_empty, fifo_full;
  logic [DATA_W-1:0] head;

  // Credits come from registered counts only, so req_ready has no path
  // from req_valid or rsp_ready.
  assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign req_ready    = !rst && (credits_used < (CNT_W+1)'(OUT_DEPTH));
  assign accept       = req_valid && req_ready;
  assign ram_re       = accept;
  assign ram_addr     = req_addr;

  assign tap       = vld_pipe_q[RD_LAT-1];
  assign rsp_valid = !rst && !fifo_empty;
  assign rsp_data  = rsp_valid ? head : '0;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    vld_pipe_d[0] = accept;
    for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(tap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      inflight_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      inflight_q <= inflight_d;
    end
  end

  ram_rd_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tap),
    .din   (ram_rdata),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
                                   credits_used <= (CNT_W+1)'(OUT_DEPTH));
  a_push_full:    assert property (@(posedge clk) disable iff (rst) !(tap && fifo_full));
endmodule

// File: tb/tb_ram_rd_port.sv
module tb_ram_rd_port;
  import ram_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  req_valid = 1'b0;
  logic  rsp_ready = 1'b1;
  addr_t req_addr = '0;

  // lane 0: RD_LAT=1 build, lane 1: RD_LAT=3 build, same stimulus
  logic  rr [2];
  logic  rv [2];
  logic  re [2];
  data_t rd [2];
  data_t rdat [2];
  addr_t ra [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_rd_port #(.RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[0]), .req_addr(req_addr),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_data(rd[0]),
    .ram_re(re[0]), .ram_addr(ra[0]), .ram_rdata(rdat[0]));

  ram_rd_port #(.RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[1]), .req_addr(req_addr),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_data(rd[1]),
    .ram_re(re[1]), .ram_addr(ra[1]), .ram_rdata(rdat[1]));

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic data_t mem_f(input addr_t a);
    return data_t'(9'h100) | data_t'(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RAM models: data for an address issued with ram_re comes back RD_LAT cycles later
  logic  pv [2][3];
  addr_t pa [2][3];
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      pv[l][0] <= re[l];
      pa[l][0] <= ra[l];
      for (int k = 1; k < 3; k++) begin
        pv[l][k] <= pv[l][k-1];
        pa[l][k] <= pa[l][k-1];
      end
    end
  end
  assign rdat[0] = pv[0][0] ? mem_f(pa[0][0]) : 9'h0AA;
  assign rdat[1] = pv[1][2] ? mem_f(pa[1][2]) : 9'h0AA;

  // Reference model: per lane, a queue of outstanding reads (accepted, not
  // yet taken) with the cycle each becomes visible. Credits = queue size.
  typedef struct {
    addr_t a;
    int    due;
  } ent_t;
  ent_t mq [2][$];
  int   cyc = 0;
  logic rst_prev = 1'b1;

  always @(posedge clk) begin
    int sz;
    bit er, ev;
    for (int l = 0; l < 2; l++) begin
      if (rst) mq[l].delete();
      else begin
        sz = mq[l].size();
        er = sz < lat_of(l) + 2;
        ev = sz > 0 && mq[l][0].due <= cyc;
        if (ev && rsp_ready) void'(mq[l].pop_front());
        if (req_valid && er) mq[l].push_back('{req_addr, cyc + lat_of(l) + 1});
      end
    end
    rst_prev = rst;
    cyc++;
  end

  always @(negedge clk) begin
    int sz;
    bit er, ev;
    for (int l = 0; l < 2; l++) begin
      sz = mq[l].size();
      er = !rst && sz < lat_of(l) + 2;
      ev = !rst && sz > 0 && mq[l][0].due <= cyc;
      chk($sformatf("L%0d req_ready", l), 32'(rr[l]), 32'(er));
      chk($sformatf("L%0d rsp_valid", l), 32'(rv[l]), 32'(ev));
      if (ev) chk($sformatf("L%0d rsp_data", l), 32'(rd[l]), 32'(mem_f(mq[l][0].a)));
      chk($sformatf("L%0d ram_re", l), 32'(re[l]), 32'(req_valid && er));
      if (re[l]) chk($sformatf("L%0d ram_addr", l), 32'(ra[l]), 32'(req_addr));
      if (rst || rst_prev) chk($sformatf("L%0d rsp_data_rst", l), 32'(rd[l]), 32'h0);
    end
  end

  data_t got [$];
  int    gotc [$];
  addr_t sent [$];
  int    acc, stalls;
  addr_t a;
  int    acc_n [2];
  int    pop_n [2];

  initial begin
    // reset with a pending request: nothing may be issued or shown
    rst = 1'b1; req_valid = 1'b1; req_addr = 5'd5; rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(rr[0]), 32'h0);
    chk("reset rsp_valid", 32'(rv[0]), 32'h0);
    chk("reset rsp_data", 32'(rd[0]), 32'h0);
    chk("reset ram_re", 32'(re[0]), 32'h0);
    step(); step();
    rst = 1'b0;

    // single read of address 5, cycle 0
    @(negedge clk);
    chk("single ram_re c0", 32'(re[0]), 32'h1);
    chk("single ram_addr c0", 32'(ra[0]), 32'h5);
    step(); req_valid = 1'b0;
    @(negedge clk);
    chk("single rsp_valid c1", 32'(rv[0]), 32'h0);
    step();
    @(negedge clk);
    chk("single rsp_valid c2", 32'(rv[0]), 32'h1);
    chk("single rsp_data c2", 32'(rd[0]), 32'h105);
    step();
    @(negedge clk);
    chk("single rsp_valid c3", 32'(rv[0]), 32'h0);
    repeat (6) step();

    // streaming 0..7 on lane 0
    got.delete(); gotc.delete();
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8);
      req_addr  = addr_t'(c);
      @(negedge clk);
      if (c < 8) chk("stream req_ready", 32'(rr[0]), 32'h1);
      if (rv[0]) begin got.push_back(rd[0]); gotc.push_back(c); end
      step();
    end
    chk("stream count", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      chk("stream data", 32'(got[k]), 32'h100 + 32'(k));
      chk("stream cycle", 32'(gotc[k]), 32'(k + 2));
    end
    req_valid = 1'b0;
    repeat (6) step();

    // backpressure on lane 0
    rsp_ready = 1'b0; req_valid = 1'b1; a = '0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_addr = a;
      @(negedge clk);
      if (re[0]) begin acc++; a = a + 1'b1; end
      step();
    end
    chk("bp accepts", 32'(acc), 32'd3);
    @(negedge clk);
    chk("bp req_ready low", 32'(rr[0]), 32'h0);
    chk("bp rsp_data held", 32'(rd[0]), 32'h100);
    step();
    rsp_ready = 1'b1; req_addr = a;
    got.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("bp ready still low", 32'(rr[0]), 32'h0);
      if (c == 1) chk("bp accept resumes", 32'(rr[0]), 32'h1);
      if (rv[0]) got.push_back(rd[0]);
      if (re[0]) a = a + 1'b1;
      step();
      req_addr = a;
    end
    chk("bp drain n", 32'(got.size() >= 3), 32'h1);
    for (int k = 0; k < 3 && k < got.size(); k++)
      chk("bp drain data", 32'(got[k]), 32'h100 + 32'(k));
    req_valid = 1'b0;
    repeat (8) step();

    // reset mid-operation: lane 1 holds 2 in flight and 1 buffered
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_addr = addr_t'($urandom);
      step();
    end
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready L1", 32'(rr[0]), 32'h1);
    chk("post-reset req_ready L3", 32'(rr[1]), 32'h1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("stale L1", 32'(rv[0]), 32'h0);
      chk("stale L3", 32'(rv[1]), 32'h0);
      step();
    end

    // RD_LAT=3: 16 random reads streamed on lane 1
    got.delete(); gotc.delete(); sent.delete(); stalls = 0;
    for (int c = 0; c < 24; c++) begin
      req_valid = (c < 16);
      req_addr  = addr_t'($urandom);
      if (c < 16) sent.push_back(req_addr);
      @(negedge clk);
      if (c < 16 && !rr[1]) stalls++;
      if (rv[1]) begin got.push_back(rd[1]); gotc.push_back(c); end
      step();
    end
    chk("lat3 stalls", 32'(stalls), 32'd0);
    chk("lat3 count", 32'(got.size()), 32'd16);
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      chk("lat3 data", 32'(got[k]), 32'(mem_f(sent[k])));
      chk("lat3 latency", 32'(gotc[k]), 32'(k + 4));
    end
    req_valid = 1'b0;
    repeat (8) step();

    // random valid/ready; the per-cycle model does the ordering checks
    acc_n = '{0, 0}; pop_n = '{0, 0};
    for (int c = 0; c < 10000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = (c < 5000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      req_addr  = addr_t'($urandom);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (re[l]) acc_n[l]++;
        if (rv[l] && rsp_ready) pop_n[l]++;
      end
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) if (rv[l]) pop_n[l]++;
      step();
    end
    chk("random L1 no loss", 32'(pop_n[0]), 32'(acc_n[0]));
    chk("random L3 no loss", 32'(pop_n[1]), 32'(acc_n[1]));
    chk("random L1 activity", 32'(acc_n[0] > 1000), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
